sort_job_master: RTL and testbench



---
 rtl/sort_job_master.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_sort_job_master.sv | 536 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_job_master.sv
// sort_job_master: host-side job initiator for the sorting-network accelerator.
// Programs the beat count over AXI-Lite, streams the input beats, starts the
// job, polls for completion, triggers writeback and forwards the results.
module sort_job_master #(
    parameter int unsigned     ADRW     = 32,
    parameter int unsigned     DATW     = 32,
    parameter int unsigned     SDATW    = 128,
    parameter logic [ADRW-1:0] BASE     = '0,
    parameter logic [ADRW-1:0] REG_BEAT = '0,
    parameter logic [ADRW-1:0] REG_CTRL = ADRW'(4),
    parameter logic [ADRW-1:0] REG_STAT = ADRW'(8),
    parameter int unsigned     POLL_GAP = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    // job command
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [19:0]       i_cmd_beat,
    output logic              o_job_done,
    output logic              o_job_err,
    // input data source
    input  logic [SDATW-1:0]  i_src_tdata,
    input  logic              i_src_tvalid,
    output logic              o_src_tready,
    // to accelerator input
    output logic [SDATW-1:0]  o_axis_tdata,
    output logic              o_axis_tlast,
    output logic              o_axis_tvalid,
    input  logic              i_axis_tready,
    // from accelerator output
    input  logic [SDATW-1:0]  i_res_tdata,
    input  logic              i_res_tlast,
    input  logic              i_res_tvalid,
    output logic              o_res_tready,
    // result sink
    output logic [SDATW-1:0]  o_dst_tdata,
    output logic              o_dst_tlast,
    output logic              o_dst_tvalid,
    input  logic              i_dst_tready,
    // AXI-Lite master
    output logic [ADRW-1:0]   o_awaddr,
    output logic              o_awvalid,
    input  logic              i_awready,
    output logic [DATW-1:0]   o_wdata,
    output logic [DATW/8-1:0] o_wstrb,
    output logic              o_wvalid,
    input  logic              i_wready,
    input  logic [1:0]        i_bresp,
    input  logic              i_bvalid,
    output logic              o_bready,
    output logic [ADRW-1:0]   o_araddr,
    output logic              o_arvalid,
    input  logic              i_arready,
    input  logic [DATW-1:0]   i_rdata,
    input  logic [1:0]        i_rresp,
    input  logic              i_rvalid,
    output logic              o_rready
);

    typedef enum logic [3:0] {
        IDLE,
        WR_BEAT,
        STREAM,
        WR_START,
        POLL_RD,
        POLL_WAIT,
        WR_WB,
        COLLECT,
        FIN
    } state_t;

    localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

    state_t      state_q, state_d;
    logic [19:0] beat_q, beat_d;
    logic [19:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        ar_done_q, ar_done_d;
    logic [15:0] gap_q, gap_d;

    // AXI-Lite write parameters selected by the current write state
    logic            is_wr;
    logic [ADRW-1:0] wr_off;
    logic [DATW-1:0] wr_val;
    state_t          wr_next;
    logic            aw_hs, w_hs, ar_hs;
    logic            last_beat;

    // only bit0 of the status word carries meaning
    logic unused_rdata;
    assign unused_rdata = ^i_rdata[DATW-1:1];

    assign last_beat = (cnt_q == beat_q - 20'd1);

    // state register and job bookkeeping
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ar_done_q <= 1'b0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            ar_done_q <= ar_done_d;
            gap_q     <= gap_d;
        end
    end

    // register/value/successor for whichever AXI-Lite write is in progress
    always_comb begin
        is_wr   = 1'b0;
        wr_off  = REG_CTRL;
        wr_val  = '0;
        wr_next = IDLE;
        unique case (state_q)
            WR_BEAT: begin
                is_wr   = 1'b1;
                wr_off  = REG_BEAT;
                wr_val  = DATW'(beat_q);
                wr_next = STREAM;
            end
            WR_START: begin
                is_wr   = 1'b1;
                wr_off  = REG_CTRL;
                wr_val  = DATW'(1);
                wr_next = POLL_RD;
            end
            WR_WB: begin
                is_wr   = 1'b1;
                wr_off  = REG_CTRL;
                wr_val  = DATW'(2);
                wr_next = COLLECT;
            end
            default: ;
        endcase
    end

    // next-state logic and all handshake/pass-through outputs
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        ar_done_d = ar_done_q;
        gap_d     = gap_q;

        o_cmd_ready   = 1'b0;
        o_job_done    = 1'b0;
        o_job_err     = 1'b0;
        o_src_tready  = 1'b0;
        o_axis_tdata  = '0;
        o_axis_tlast  = 1'b0;
        o_axis_tvalid = 1'b0;
        o_res_tready  = 1'b0;
        o_dst_tdata   = '0;
        o_dst_tlast   = 1'b0;
        o_dst_tvalid  = 1'b0;
        o_awaddr      = '0;
        o_awvalid     = 1'b0;
        o_wdata       = '0;
        o_wstrb       = '0;
        o_wvalid      = 1'b0;
        o_bready      = 1'b0;
        o_araddr      = '0;
        o_arvalid     = 1'b0;
        o_rready      = 1'b0;

        aw_hs = 1'b0;
        w_hs  = 1'b0;
        ar_hs = 1'b0;

        if (is_wr) begin
            o_awaddr  = BASE + wr_off;
            o_awvalid = !aw_done_q;
            o_wdata   = wr_val;
            o_wstrb   = '1;
            o_wvalid  = !w_done_q;
            o_bready  = 1'b1;
            aw_hs     = o_awvalid && i_awready;
            w_hs      = o_wvalid && i_wready;
            if (aw_hs) aw_done_d = 1'b1;
            if (w_hs)  w_done_d  = 1'b1;
            if (i_bvalid && (aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                cnt_d     = '0;
                if (i_bresp != 2'b00) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    state_d = wr_next;
                end
            end
        end

        unique case (state_q)
            IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    beat_d    = i_cmd_beat;
                    err_d     = 1'b0;
                    cnt_d     = '0;
                    gap_d     = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    ar_done_d = 1'b0;
                    if (i_cmd_beat == 20'd0) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        state_d = WR_BEAT;
                    end
                end
            end
            STREAM: begin
                o_axis_tdata  = i_src_tdata;
                o_axis_tvalid = i_src_tvalid;
                o_axis_tlast  = last_beat;
                o_src_tready  = i_axis_tready;
                if (i_src_tvalid && i_axis_tready) begin
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = WR_START;
                    end else begin
                        cnt_d = cnt_q + 20'd1;
                    end
                end
            end
            POLL_RD: begin
                o_araddr  = BASE + REG_STAT;
                o_arvalid = !ar_done_q;
                o_rready  = 1'b1;
                ar_hs     = o_arvalid && i_arready;
                if (ar_hs) ar_done_d = 1'b1;
                if (i_rvalid) begin
                    ar_done_d = 1'b0;
                    if (i_rresp != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else if (i_rdata[0]) begin
                        state_d = WR_WB;
                    end else begin
                        gap_d   = '0;
                        state_d = POLL_WAIT;
                    end
                end
            end
            POLL_WAIT: begin
                if (gap_q == GAP_LAST) begin
                    state_d = POLL_RD;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            COLLECT: begin
                o_dst_tdata  = i_res_tdata;
                o_dst_tvalid = i_res_tvalid;
                o_dst_tlast  = last_beat;
                o_res_tready = i_dst_tready;
                if (i_res_tvalid && i_dst_tready) begin
                    if (i_res_tlast != last_beat) err_d = 1'b1;
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = FIN;
                    end else begin
                        cnt_d = cnt_q + 20'd1;
                    end
                end
            end
            FIN: begin
                o_job_done = 1'b1;
                o_job_err  = err_q;
                state_d    = IDLE;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sort_job_master.sv
// Self-checking bench for sort_job_master: a behavioural accelerator/stream
// environment records every transaction, and each scenario compares the logs
// against expectations derived from the job rules.
module tb_sort_job_master;

    localparam int unsigned GAP = 16;

    logic         i_clk;
    logic         i_rst;
    logic         i_cmd_valid;
    logic         o_cmd_ready;
    logic [19:0]  i_cmd_beat;
    logic         o_job_done;
    logic         o_job_err;
    logic [127:0] i_src_tdata;
    logic         i_src_tvalid;
    logic         o_src_tready;
    logic [127:0] o_axis_tdata;
    logic         o_axis_tlast;
    logic         o_axis_tvalid;
    logic         i_axis_tready;
    logic [127:0] i_res_tdata;
    logic         i_res_tlast;
    logic         i_res_tvalid;
    logic         o_res_tready;
    logic [127:0] o_dst_tdata;
    logic         o_dst_tlast;
    logic         o_dst_tvalid;
    logic         i_dst_tready;
    logic [31:0]  o_awaddr;
    logic         o_awvalid;
    logic         i_awready;
    logic [31:0]  o_wdata;
    logic [3:0]   o_wstrb;
    logic         o_wvalid;
    logic         i_wready;
    logic [1:0]   i_bresp;
    logic         i_bvalid;
    logic         o_bready;
    logic [31:0]  o_araddr;
    logic         o_arvalid;
    logic         i_arready;
    logic [31:0]  i_rdata;
    logic [1:0]   i_rresp;
    logic         i_rvalid;
    logic         o_rready;

    sort_job_master #(
        .ADRW(32), .DATW(32), .SDATW(128),
        .BASE(32'h0), .REG_BEAT(32'h0), .REG_CTRL(32'h4), .REG_STAT(32'h8),
        .POLL_GAP(GAP)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_beat(i_cmd_beat),
        .o_job_done(o_job_done), .o_job_err(o_job_err),
        .i_src_tdata(i_src_tdata), .i_src_tvalid(i_src_tvalid), .o_src_tready(o_src_tready),
        .o_axis_tdata(o_axis_tdata), .o_axis_tlast(o_axis_tlast),
        .o_axis_tvalid(o_axis_tvalid), .i_axis_tready(i_axis_tready),
        .i_res_tdata(i_res_tdata), .i_res_tlast(i_res_tlast),
        .i_res_tvalid(i_res_tvalid), .o_res_tready(o_res_tready),
        .o_dst_tdata(o_dst_tdata), .o_dst_tlast(o_dst_tlast),
        .o_dst_tvalid(o_dst_tvalid), .i_dst_tready(i_dst_tready),
        .o_awaddr(o_awaddr), .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(i_wready),
        .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
        .o_araddr(o_araddr), .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // job configuration (written only by the test sequence)
    int           job_id = 0;
    int           cfg_n = 0;
    bit           cfg_skew = 0;
    bit           cfg_bp = 0;
    int           cfg_done_after = 1;
    bit           cfg_bresp_start = 0;
    logic [127:0] src_data [64];
    logic [127:0] res_data [64];
    logic         res_last [64];

    // transaction logs (written only by the environment process)
    int           wr_n, ar_n, rd_n, acc_n, dst_n, wstrb_bad, cyc;
    logic [31:0]  wr_addr [64];
    logic [31:0]  wr_data [64];
    int           ar_cyc [64];
    logic [127:0] acc_data [64];
    logic         acc_last [64];
    logic [127:0] dst_data [64];
    logic         dst_last [64];

    // accelerator + source/sink environment: samples handshakes on the falling
    // edge, updates its drives just after the rising edge
    initial begin : env
        int          seen_id;
        int          src_idx, res_idx;
        bit          aw_got, w_got, b_pend, r_pend;
        logic [31:0] aw_a, w_d, r_d;
        logic [1:0]  b_r;
        seen_id = -1;
        src_idx = 0; res_idx = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        aw_a = '0; w_d = '0; r_d = '0; b_r = '0;
        wr_n = 0; ar_n = 0; rd_n = 0; acc_n = 0; dst_n = 0; wstrb_bad = 0; cyc = 0;
        i_src_tdata = '0; i_src_tvalid = 0; i_axis_tready = 1;
        i_res_tdata = '0; i_res_tlast = 0; i_res_tvalid = 0; i_dst_tready = 1;
        i_awready = 1; i_wready = 1; i_bresp = '0; i_bvalid = 0;
        i_arready = 1; i_rdata = '0; i_rresp = '0; i_rvalid = 0;
        forever begin
            @(negedge i_clk);
            cyc++;
            if (job_id != seen_id) begin
                seen_id = job_id;
                src_idx = 0; res_idx = 0;
                wr_n = 0; ar_n = 0; rd_n = 0; acc_n = 0; dst_n = 0; wstrb_bad = 0;
            end
            if (i_rst) begin
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
            end else begin
                if (i_bvalid && o_bready) b_pend = 0;
                if (i_rvalid && o_rready) begin
                    r_pend = 0;
                    rd_n++;
                end
                if (o_awvalid && i_awready) begin
                    aw_got = 1;
                    aw_a = o_awaddr;
                end
                if (o_wvalid && i_wready) begin
                    w_got = 1;
                    w_d = o_wdata;
                    if (o_wstrb !== 4'hF) wstrb_bad++;
                end
                if (aw_got && w_got) begin
                    aw_got = 0; w_got = 0;
                    if (wr_n < 64) begin
                        wr_addr[wr_n] = aw_a;
                        wr_data[wr_n] = w_d;
                    end
                    wr_n++;
                    b_pend = 1;
                    b_r = (cfg_bresp_start && aw_a == 32'h4 && w_d == 32'h1) ? 2'b10 : 2'b00;
                end
                if (o_arvalid && i_arready) begin
                    if (ar_n < 64) ar_cyc[ar_n] = cyc;
                    ar_n++;
                    r_pend = 1;
                    r_d = (ar_n >= cfg_done_after) ? 32'h1 : 32'h0;
                end
                if (i_src_tvalid && o_src_tready) src_idx++;
                if (i_res_tvalid && o_res_tready) res_idx++;
                if (o_axis_tvalid && i_axis_tready) begin
                    if (acc_n < 64) begin
                        acc_data[acc_n] = o_axis_tdata;
                        acc_last[acc_n] = o_axis_tlast;
                    end
                    acc_n++;
                end
                if (o_dst_tvalid && i_dst_tready) begin
                    if (dst_n < 64) begin
                        dst_data[dst_n] = o_dst_tdata;
                        dst_last[dst_n] = o_dst_tlast;
                    end
                    dst_n++;
                end
            end
            @(posedge i_clk);
            #1;
            i_bvalid = b_pend;
            i_bresp  = b_r;
            i_rvalid = r_pend;
            i_rdata  = r_d;
            i_rresp  = 2'b00;
            i_awready = cfg_skew ? 1'($urandom_range(0, 1)) : 1'b1;
            i_wready  = cfg_skew ? 1'($urandom_range(0, 1)) : 1'b1;
            i_arready = cfg_skew ? 1'($urandom_range(0, 1)) : 1'b1;
            i_axis_tready = cfg_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            i_dst_tready  = cfg_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            i_src_tvalid = (src_idx < cfg_n);
            i_src_tdata  = (src_idx < cfg_n) ? src_data[src_idx] : '0;
            i_res_tvalid = (res_idx < cfg_n);
            i_res_tdata  = (res_idx < cfg_n) ? res_data[res_idx] : '0;
            i_res_tlast  = (res_idx < cfg_n) ? res_last[res_idx] : 1'b0;
        end
    end

    // ---- reference model: what a job of n beats must produce ----
    // register writes in order: beat count, start, writeback
    function automatic int wr_mismatch(input int n, input int cnt);
        logic [31:0] ea [3];
        logic [31:0] ed [3];
        int bad;
        ea[0] = 32'h0; ed[0] = 32'(n);
        ea[1] = 32'h4; ed[1] = 32'h1;
        ea[2] = 32'h4; ed[2] = 32'h2;
        bad = 0;
        for (int j = 0; j < cnt && j < 3; j++)
            if (wr_addr[j] !== ea[j] || wr_data[j] !== ed[j]) bad++;
        return bad;
    endfunction

    // accelerator input = source data in order, tlast on the final beat only
    function automatic int acc_mismatch(input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++)
            if (acc_data[i] !== src_data[i] || acc_last[i] !== (i == n - 1)) bad++;
        return bad;
    endfunction

    // sink = result data in order, tlast by beat count regardless of received tlast
    function automatic int dst_mismatch(input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++)
            if (dst_data[i] !== res_data[i] || dst_last[i] !== (i == n - 1)) bad++;
        return bad;
    endfunction

    task automatic setup_job(input int n, input bit skew, input bit bp,
                             input int done_after, input bit bresp, input int bad_idx);
        cfg_n = n;
        cfg_skew = skew;
        cfg_bp = bp;
        cfg_done_after = done_after;
        cfg_bresp_start = bresp;
        for (int i = 0; i < n; i++) begin
            src_data[i] = {$urandom, $urandom, $urandom, $urandom};
            res_data[i] = {$urandom, $urandom, $urandom, $urandom};
            res_last[i] = (bad_idx >= 0) ? (i == bad_idx) : (i == n - 1);
        end
        job_id++;
    endtask

    task automatic issue_cmd(input int n, output bit to);
        @(negedge i_clk);
        @(posedge i_clk);
        #1;
        i_cmd_valid = 1'b1;
        i_cmd_beat  = 20'(n);
        to = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clk);
            if (o_cmd_ready) begin
                to = 0;
                break;
            end
        end
        @(posedge i_clk);
        #1;
        i_cmd_valid = 1'b0;
        i_cmd_beat  = '0;
    endtask

    task automatic run_job(input int n, output bit to, output bit err,
                           output int lat, output bit pulse_long);
        err = 0;
        lat = 0;
        issue_cmd(n, to);
        if (!to) begin
            to = 1;
            for (int k = 0; k < 3000; k++) begin
                @(negedge i_clk);
                lat++;
                if (o_job_done) begin
                    err = o_job_err;
                    to = 0;
                    break;
                end
            end
        end
        @(negedge i_clk);
        pulse_long = o_job_done;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd_beat = '0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        n_tests++;
        if ({o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_src_tready,
             o_axis_tvalid, o_res_tready, o_dst_tvalid, o_job_done, o_job_err} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_valids: got %b want 0", {o_awvalid, o_wvalid, o_bready,
                     o_arvalid, o_rready, o_src_tready, o_axis_tvalid, o_res_tready,
                     o_dst_tvalid, o_job_done, o_job_err});
        end
        n_tests++;
        if (o_cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cmd_ready: got %b want 1", o_cmd_ready);
        end
        n_tests++;
        if (o_awaddr !== 32'h0 || o_araddr !== 32'h0 || o_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_addr_data: got aw=%h ar=%h w=%h want 0", o_awaddr, o_araddr, o_wdata);
        end
    endtask

    task automatic test_basic();
        bit to, err, pl;
        int lat;
        setup_job(4, 0, 0, 2, 0, -1);
        run_job(4, to, err, lat, pl);
        n_tests++;
        if (to !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: timeout=%b err=%b want 0/0", to, err);
        end
        n_tests++;
        if (wr_n !== 3 || wr_mismatch(4, 3) !== 0) begin
            n_fail++;
            $display("FAIL basic_writes: count=%0d bad=%0d want 3/0", wr_n, wr_mismatch(4, 3));
        end
        n_tests++;
        if (acc_n !== 4 || acc_mismatch(4) !== 0) begin
            n_fail++;
            $display("FAIL basic_input_stream: count=%0d bad=%0d want 4/0", acc_n, acc_mismatch(4));
        end
        n_tests++;
        if (ar_n !== 2) begin
            n_fail++;
            $display("FAIL basic_polls: got %0d want 2", ar_n);
        end
        n_tests++;
        if (ar_cyc[1] - ar_cyc[0] !== int'(GAP) + 2) begin
            n_fail++;
            $display("FAIL basic_poll_gap: got %0d want %0d", ar_cyc[1] - ar_cyc[0], GAP + 2);
        end
        n_tests++;
        if (dst_n !== 4 || dst_mismatch(4) !== 0) begin
            n_fail++;
            $display("FAIL basic_results: count=%0d bad=%0d want 4/0", dst_n, dst_mismatch(4));
        end
        n_tests++;
        if (pl !== 1'b0 || wstrb_bad !== 0) begin
            n_fail++;
            $display("FAIL basic_pulse_wstrb: done_held=%b bad_wstrb=%0d want 0/0", pl, wstrb_bad);
        end
    endtask

    task automatic test_backpressure();
        bit to, err, pl;
        int lat;
        setup_job(8, 1, 1, 1, 0, -1);
        run_job(8, to, err, lat, pl);
        n_tests++;
        if (to !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_done: timeout=%b err=%b want 0/0", to, err);
        end
        n_tests++;
        if (wr_n !== 3 || wr_mismatch(8, 3) !== 0) begin
            n_fail++;
            $display("FAIL bp_writes: count=%0d bad=%0d want 3/0", wr_n, wr_mismatch(8, 3));
        end
        n_tests++;
        if (acc_n !== 8 || acc_mismatch(8) !== 0) begin
            n_fail++;
            $display("FAIL bp_input_stream: count=%0d bad=%0d want 8/0", acc_n, acc_mismatch(8));
        end
        n_tests++;
        if (dst_n !== 8 || dst_mismatch(8) !== 0) begin
            n_fail++;
            $display("FAIL bp_results: count=%0d bad=%0d want 8/0", dst_n, dst_mismatch(8));
        end
    endtask

    task automatic test_zero_beat();
        bit to, err, pl;
        int lat;
        setup_job(0, 0, 0, 1, 0, -1);
        run_job(0, to, err, lat, pl);
        n_tests++;
        if (to !== 1'b0 || lat !== 1 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_beat_done: timeout=%b latency=%0d err=%b want 0/1/1", to, lat, err);
        end
        n_tests++;
        if (wr_n !== 0 || ar_n !== 0 || acc_n !== 0 || dst_n !== 0) begin
            n_fail++;
            $display("FAIL zero_beat_traffic: wr=%0d ar=%0d in=%0d out=%0d want all 0",
                     wr_n, ar_n, acc_n, dst_n);
        end
    endtask

    task automatic test_bresp_err();
        bit to, err, pl;
        int lat;
        setup_job(3, 0, 0, 1, 1, -1);
        run_job(3, to, err, lat, pl);
        n_tests++;
        if (to !== 1'b0 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL bresp_done: timeout=%b err=%b want 0/1", to, err);
        end
        n_tests++;
        if (wr_n !== 2 || wr_mismatch(3, 2) !== 0 || ar_n !== 0 || dst_n !== 0) begin
            n_fail++;
            $display("FAIL bresp_traffic: wr=%0d bad=%0d ar=%0d out=%0d want 2/0/0/0",
                     wr_n, wr_mismatch(3, 2), ar_n, dst_n);
        end
    endtask

    task automatic test_tlast_err();
        bit to, err, pl;
        int lat;
        setup_job(4, 0, 0, 1, 0, 1);
        run_job(4, to, err, lat, pl);
        n_tests++;
        if (to !== 1'b0 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL tlast_done: timeout=%b err=%b want 0/1", to, err);
        end
        n_tests++;
        if (dst_n !== 4 || dst_mismatch(4) !== 0 || wr_n !== 3) begin
            n_fail++;
            $display("FAIL tlast_results: count=%0d bad=%0d wr=%0d want 4/0/3",
                     dst_n, dst_mismatch(4), wr_n);
        end
    endtask

    task automatic test_reset_mid_job();
        bit to, err, pl;
        int lat;
        setup_job(3, 0, 0, 100, 0, -1);
        issue_cmd(3, to);
        if (!to) begin
            to = 1;
            for (int k = 0; k < 500; k++) begin
                @(negedge i_clk);
                if (rd_n >= 1) begin
                    to = 0;
                    break;
                end
            end
        end
        n_tests++;
        if (to !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_reach_poll: timeout=%b want 0", to);
        end
        @(posedge i_clk);
        #1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        n_tests++;
        if ({o_awvalid, o_wvalid, o_arvalid, o_rready, o_bready, o_src_tready,
             o_axis_tvalid, o_res_tready, o_dst_tvalid, o_job_done} !== 10'b0
            || o_cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_outputs: valids=%b cmd_ready=%b want 0/1",
                     {o_awvalid, o_wvalid, o_arvalid, o_rready, o_bready, o_src_tready,
                      o_axis_tvalid, o_res_tready, o_dst_tvalid, o_job_done}, o_cmd_ready);
        end
        repeat (GAP + 6) @(negedge i_clk);
        n_tests++;
        if (ar_n !== 1 || o_job_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_quiet: polls=%0d done=%b want 1/0", ar_n, o_job_done);
        end
        @(posedge i_clk);
        #1;
        setup_job(1, 0, 0, 1, 0, -1);
        run_job(1, to, err, lat, pl);
        n_tests++;
        if (to !== 1'b0 || err !== 1'b0 || wr_n !== 3 || wr_mismatch(1, 3) !== 0
            || acc_mismatch(1) !== 0 || dst_n !== 1 || dst_mismatch(1) !== 0) begin
            n_fail++;
            $display("FAIL midrst_new_job: timeout=%b err=%b wr=%0d out=%0d want 0/0/3/1",
                     to, err, wr_n, dst_n);
        end
    endtask

    task automatic test_back_to_back();
        bit to, err, pl;
        int lat, n, da;
        for (int j = 0; j < 4; j++) begin
            n  = $urandom_range(1, 12);
            da = $urandom_range(1, 3);
            setup_job(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), da, 0, -1);
            run_job(n, to, err, lat, pl);
            n_tests++;
            if (to !== 1'b0 || err !== 1'b0 || ar_n !== da) begin
                n_fail++;
                $display("FAIL b2b_job%0d_done: timeout=%b err=%b polls=%0d want 0/0/%0d",
                         j, to, err, ar_n, da);
            end
            n_tests++;
            if (wr_n !== 3 || wr_mismatch(n, 3) !== 0 || acc_n !== n || acc_mismatch(n) !== 0
                || dst_n !== n || dst_mismatch(n) !== 0) begin
                n_fail++;
                $display("FAIL b2b_job%0d_data: wr=%0d in=%0d/%0d out=%0d/%0d want 3 and %0d beats clean",
                         j, wr_n, acc_n, acc_mismatch(n), dst_n, dst_mismatch(n), n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_beat();
        test_bresp_err();
        test_tlast_err();
        test_reset_mid_job();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
